// File: rtl/fish_sprite_renderer_pkg.sv
// Shared constants and types for the sprite renderers (fish, hook, boat).
// Sprite ROM geometry here must match every sprite ROM in the build.
package fish_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;
    localparam int COLOR_W  = 12;

    localparam logic [COLOR_W-1:0] KEY_WHITE = 12'hFFF;

    localparam int SPR_W_DEF = 32;
    localparam int SPR_H_DEF = 16;
    localparam int SPR_ROW_W = 4;
    localparam int SPR_COL_W = 5;

    typedef enum logic {
        UPD_CLEAN   = 1'b0,
        UPD_PENDING = 1'b1
    } upd_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               flip;
        logic               show;
    } spr_pos_t;

endpackage

// File: rtl/fish_sprite_renderer_if.sv
// Bundle of update, pixel, ROM and output signals for fish_sprite_renderer.
// slave = renderer side, master = driver / ROM side.
interface fish_sprite_renderer_if
    import fish_pkg::*;
();

    logic                 frame_tick;
    logic                 upd_valid;
    logic [COORD_W-1:0]   upd_x;
    logic [COORD_W-1:0]   upd_y;
    logic                 upd_flip;
    logic                 upd_show;
    logic [COORD_W-1:0]   pix_x;
    logic [COORD_W-1:0]   pix_y;
    logic                 pix_valid;
    logic [SPR_ROW_W-1:0] rom_row;
    logic [SPR_COL_W-1:0] rom_col;
    logic [COLOR_W-1:0]   rom_data;
    logic                 out_valid;
    logic                 out_hit;
    logic [COLOR_W-1:0]   out_color;

    modport slave (
        input  frame_tick, upd_valid, upd_x, upd_y, upd_flip, upd_show,
        input  pix_x, pix_y, pix_valid, rom_data,
        output rom_row, rom_col, out_valid, out_hit, out_color
    );

    modport master (
        output frame_tick, upd_valid, upd_x, upd_y, upd_flip, upd_show,
        output pix_x, pix_y, pix_valid, rom_data,
        input  rom_row, rom_col, out_valid, out_hit, out_color
    );

endinterface

// File: rtl/fish_sprite_renderer_pos_shadow.sv
// Shadow/active sprite position registers with CLEAN/PENDING update FSM.
// Active position only changes on frame_tick so a sprite never tears.
module sprite_pos_shadow
    import fish_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     i_frame_tick,
    input  logic     i_upd_valid,
    input  spr_pos_t i_upd,
    output spr_pos_t o_act
);

    upd_state_t r_state;
    upd_state_t w_next;
    spr_pos_t   r_shadow;
    spr_pos_t   r_act;
    logic       w_ld_shadow;
    logic       w_ld_act_upd;
    logic       w_ld_act_shd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= UPD_CLEAN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (i_upd_valid && i_frame_tick) begin
            w_next = UPD_CLEAN;
        end else if (i_upd_valid) begin
            w_next = UPD_PENDING;
        end else if (i_frame_tick) begin
            w_next = UPD_CLEAN;
        end
    end

    // A coincident update bypasses the shadow straight into active.
    always_comb begin
        w_ld_shadow  = i_upd_valid;
        w_ld_act_upd = i_upd_valid & i_frame_tick;
        w_ld_act_shd = ~i_upd_valid & i_frame_tick &
                       (r_state == UPD_PENDING);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow <= '0;
            r_act    <= '0;
        end else begin
            if (w_ld_shadow) begin
                r_shadow <= i_upd;
            end
            if (w_ld_act_upd) begin
                r_act <= i_upd;
            end else if (w_ld_act_shd) begin
                r_act <= r_shadow;
            end
        end
    end

    assign o_act = r_act;

endmodule

// File: rtl/fish_sprite_renderer.sv
// Fish sprite pixel reader: hit test, ROM addressing, colour key, 2-clock pipe.
// Optional FISH_BOB_EN: sprite bobs down 1 line every 16 frames.
module fish_sprite_renderer
    import fish_pkg::*;
#(
    parameter int                 SPR_W     = SPR_W_DEF,
    parameter int                 SPR_H     = SPR_H_DEF,
    parameter logic [COLOR_W-1:0] KEY_COLOR = KEY_WHITE
)(
    input  logic                  clk,
    input  logic                  reset_n,
    fish_sprite_renderer_if.slave bus
);

    localparam logic [COORD_W:0]    W11     = (COORD_W+1)'(SPR_W);
    localparam logic [COORD_W:0]    H11     = (COORD_W+1)'(SPR_H);
    localparam logic [SPR_COL_W-1:0] COL_MAX = SPR_COL_W'(SPR_W - 1);

    spr_pos_t w_upd;
    spr_pos_t w_act;

    assign w_upd = '{
        x:    bus.upd_x,
        y:    bus.upd_y,
        flip: bus.upd_flip,
        show: bus.upd_show
    };

    sprite_pos_shadow u_pos (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_frame_tick (bus.frame_tick),
        .i_upd_valid  (bus.upd_valid),
        .i_upd        (w_upd),
        .o_act        (w_act)
    );

    logic w_bob;

`ifdef FISH_BOB_EN
    logic [3:0] r_frame_cnt;
    logic       r_bob;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= 4'd0;
            r_bob       <= 1'b0;
        end else if (bus.frame_tick) begin
            r_frame_cnt <= r_frame_cnt + 4'd1;
            if (r_frame_cnt == 4'hF) begin
                r_bob <= ~r_bob;
            end
        end
    end

    assign w_bob = r_bob;
`else
    assign w_bob = 1'b0;
`endif

    logic [COORD_W:0]     w_eff_y;
    logic [COORD_W:0]     w_px;
    logic [COORD_W:0]     w_py;
    logic [COORD_W:0]     w_ax;
    logic                 w_in_spr;
    logic [SPR_COL_W-1:0] w_dx;
    logic [SPR_ROW_W-1:0] w_dy;
    logic [SPR_COL_W-1:0] w_col;

    assign w_eff_y = {1'b0, w_act.y} + {{COORD_W{1'b0}}, w_bob};
    assign w_px    = {1'b0, bus.pix_x};
    assign w_py    = {1'b0, bus.pix_y};
    assign w_ax    = {1'b0, w_act.x};

    // 11-bit bounds: sprites past the right/bottom edge clip, never wrap.
    assign w_in_spr = w_act.show & bus.pix_valid &
                      (w_px >= w_ax) & (w_px < w_ax + W11) &
                      (w_py >= w_eff_y) & (w_py < w_eff_y + H11);

    assign w_dx  = bus.pix_x[SPR_COL_W-1:0] - w_act.x[SPR_COL_W-1:0];
    assign w_dy  = bus.pix_y[SPR_ROW_W-1:0] - w_eff_y[SPR_ROW_W-1:0];
    assign w_col = w_act.flip ? (COL_MAX - w_dx) : w_dx;

    assign bus.rom_row = w_in_spr ? w_dy  : '0;
    assign bus.rom_col = w_in_spr ? w_col : '0;

    logic               r_s1_in;
    logic               r_s1_valid;
    logic               r_out_valid;
    logic               r_out_hit;
    logic [COLOR_W-1:0] r_out_color;
    logic               w_opaque;

    assign w_opaque = r_s1_in & (bus.rom_data != KEY_COLOR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_in     <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_hit   <= 1'b0;
            r_out_color <= '0;
        end else begin
            r_s1_in     <= w_in_spr;
            r_s1_valid  <= bus.pix_valid;
            r_out_valid <= r_s1_valid;
            r_out_hit   <= w_opaque;
            r_out_color <= w_opaque ? bus.rom_data : '0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_hit   = r_out_hit;
    assign bus.out_color = r_out_color;

endmodule

// File: tb/tb_fish_sprite_renderer.sv
// Directed bench for fish_sprite_renderer with a registered ROM model
// and a scoreboard queue of expected outputs; honours FISH_BOB_EN.
module tb_fish_sprite_renderer;
    import fish_pkg::*;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    fish_sprite_renderer_if bus();

    fish_sprite_renderer #(
        .SPR_W     (32),
        .SPR_H     (16),
        .KEY_COLOR (12'hFFF)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [11:0] rom_fn(logic [3:0] r, logic [4:0] c);
        return (r == c[3:0]) ? 12'hFFF : {r, 3'b000, c};
    endfunction

    always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_row, bus.rom_col);

    typedef struct {
        bit          v;
        bit          h;
        logic [11:0] c;
    } exp_t;

    exp_t q[$];
    int checks;
    int failures;

    int m_x, m_y, s_x, s_y;
    bit m_flip, m_show, s_flip, s_show, m_pend;
    int m_cnt;
    bit m_bob;

    logic [9:0] u_x, u_y;
    bit u_flip, u_show;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_flip = 0; m_show = 0;
        s_x = 0; s_y = 0; s_flip = 0; s_show = 0;
        m_pend = 0; m_cnt = 0; m_bob = 0;
    endtask

    task automatic tick(input bit pv, input int px, input int py,
                        input bit ft, input bit uv);
        exp_t e;
        int eff, dx, r, c;
        bit inn;
        logic [11:0] rd;
        @(negedge clk);
        bus.pix_valid  = pv;
        bus.pix_x      = 10'(px);
        bus.pix_y      = 10'(py);
        bus.frame_tick = ft;
        bus.upd_valid  = uv;
        bus.upd_x      = u_x;
        bus.upd_y      = u_y;
        bus.upd_flip   = u_flip;
        bus.upd_show   = u_show;
        eff = m_y + int'(m_bob);
        inn = m_show && pv && px >= m_x && px < m_x + 32 &&
              py >= eff && py < eff + 16;
        dx = px - m_x;
        r = inn ? (py - eff) : 0;
        c = inn ? (m_flip ? 31 - dx : dx) : 0;
        #1;
        chk("rom_row", bus.rom_row, r);
        chk("rom_col", bus.rom_col, c);
        rd = rom_fn(4'(r), 5'(c));
        e.v = pv;
        e.h = inn && (rd != 12'hFFF);
        e.c = e.h ? rd : 12'h000;
        q.push_back(e);
        if (uv && ft) begin
            m_x = int'(u_x); m_y = int'(u_y); m_flip = u_flip; m_show = u_show;
            s_x = m_x; s_y = m_y; s_flip = m_flip; s_show = m_show;
            m_pend = 0;
        end else if (uv) begin
            s_x = int'(u_x); s_y = int'(u_y); s_flip = u_flip; s_show = u_show;
            m_pend = 1;
        end else if (ft && m_pend) begin
            m_x = s_x; m_y = s_y; m_flip = s_flip; m_show = s_show;
            m_pend = 0;
        end
`ifdef FISH_BOB_EN
        if (ft) begin
            if (m_cnt == 15) m_bob = ~m_bob;
            m_cnt = (m_cnt + 1) % 16;
        end
`endif
        @(posedge clk);
        #1;
        if (q.size() >= 2) begin
            e = q.pop_front();
            chk("out_valid", bus.out_valid, e.v);
            chk("out_hit", bus.out_hit, e.h);
            chk("out_color", bus.out_color, e.c);
        end
    endtask

    // Called just after a posedge; changes only comb address inputs.
    task automatic addr_at(input string tag, input int px, input int py,
                           input int er, input int ec);
        bus.pix_valid = 1'b1;
        bus.pix_x     = 10'(px);
        bus.pix_y     = 10'(py);
        #1;
        chk({tag, "_row"}, bus.rom_row, er);
        chk({tag, "_col"}, bus.rom_col, ec);
    endtask

    task automatic scan(input int x0, input int x1, input int y0,
                        input int y1);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                tick(1'b1, x, y, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic set_upd(input int x, input int y, input bit f,
                           input bit s);
        u_x = 10'(x); u_y = 10'(y); u_flip = f; u_show = s;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        bus.frame_tick = 0; bus.upd_valid = 0;
        bus.upd_x = 0; bus.upd_y = 0; bus.upd_flip = 0; bus.upd_show = 0;
        bus.pix_x = 0; bus.pix_y = 0; bus.pix_valid = 0;
        set_upd(0, 0, 0, 0);
        model_reset();
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_hit", bus.out_hit, 0);
        chk("rst_out_color", bus.out_color, 0);
        chk("rst_rom_row", bus.rom_row, 0);
        chk("rst_rom_col", bus.rom_col, 0);
        @(negedge clk);
        reset_n = 1'b1;

        scan(95, 135, 48, 52);

        set_upd(100, 50, 0, 1);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 1, 0);
        addr_at("tl", 100, 50, 0, 0);
        addr_at("br", 131, 65, 15, 31);
        scan(98, 133, 49, 66);

        set_upd(100, 50, 1, 1);
        tick(0, 0, 0, 1, 1);
        addr_at("flip_l", 100, 50, 0, 31);
        addr_at("flip_r", 131, 50, 0, 0);
        scan(98, 133, 50, 50);
        scan(98, 133, 65, 65);

        set_upd(620, 470, 0, 1);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 1, 0);
        scan(600, 639, 466, 479);
        scan(0, 15, 0, 7);

        set_upd(200, 100, 0, 1);
        tick(0, 0, 0, 0, 1);
        addr_at("pend_old", 625, 470, 0, 5);
        scan(615, 639, 470, 471);
        scan(198, 233, 100, 100);
        tick(0, 0, 0, 1, 0);
        addr_at("pend_new", 200, 100, 0, 0);
        scan(198, 233, 100, 101);

`ifdef FISH_BOB_EN
        begin
            bit b0;
            set_upd(100, 50, 0, 1);
            tick(0, 0, 0, 0, 1);
            tick(0, 0, 0, 1, 0);
            while (m_cnt != 0) tick(0, 0, 0, 1, 0);
            b0 = m_bob;
            scan(100, 105, 49, 52);
            repeat (16) tick(0, 0, 0, 1, 0);
            addr_at("bob_16", 110, 50 + int'(!b0), 0, 10);
            scan(100, 105, 49, 52);
            repeat (16) tick(0, 0, 0, 1, 0);
            addr_at("bob_32", 110, 50 + int'(b0), 0, 10);
            scan(100, 105, 49, 52);
        end
`endif

        set_upd(100, 50, 0, 1);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 1, 0);
        tick(1, 110, 55, 0, 0);
        tick(1, 111, 55, 0, 0);
        tick(1, 112, 55, 0, 0);
        chk("pre_rst_valid", bus.out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_hit", bus.out_hit, 0);
        chk("async_rst_color", bus.out_color, 0);
        q.delete();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        scan(108, 114, 55, 55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fish_sprite_renderer.md
Name: fish_sprite_renderer

Overview:
- Pixel-side reader for the 32x16 fish sprite ROMs (4-bit row, 5-bit col, 12-bit RGB, one-clock registered address).
- Takes the VGA pixel coordinate stream and computes the sprite-local address, driving it into the ROM.
- Aligns the returned colour with the pixel pipeline, applies the white colour key, and emits a per-pixel hit flag and colour for the top-level layer mux.
- Sprite position and orientation update only at frame boundaries, so the sprite never tears mid-frame.

Parameters:
- SPR_W, 32, sprite width in pixels; must equal 2^(ROM col width).
- SPR_H, 16, sprite height in pixels; must equal 2^(ROM row width).
- KEY_COLOR, 12'hFFF, transparent colour; a pixel with this value reports no hit.

Ports:
- clk  in  1  system/pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- upd_valid  in  1  position-update request strobe.
- upd_x  in  10  new sprite left edge, screen x.
- upd_y  in  10  new sprite top edge, screen y.
- upd_flip  in  1  1 = mirror horizontally (fish faces left).
- upd_show  in  1  1 = sprite visible.
- pix_x  in  10  current pixel x.
- pix_y  in  10  current pixel y.
- pix_valid  in  1  video_on for the current pixel.
- rom_row  out  4  sprite ROM row address (combinational).
- rom_col  out  5  sprite ROM col address (combinational).
- rom_data  in  12  ROM colour; valid one clock after the address.
- out_valid  out  1  delayed pix_valid.
- out_hit  out  1  opaque sprite pixel at this position.
- out_color  out  12  rom_data when out_hit, else 12'h000.

Behaviour:
- Shadow/active registers, 2-state FSM {CLEAN, PENDING}:
  - upd_valid captures upd_* into shadow regs and moves to PENDING; a later upd_valid overwrites the shadow.
  - On frame_tick in PENDING: shadow copies to active regs and the FSM returns to CLEAN.
  - On frame_tick in CLEAN: no change.
  - upd_valid and frame_tick in the same cycle: the new upd_* values go directly to active, and the FSM ends CLEAN.
- Hit test (stage 0, combinational):
  - Sprite y is eff_y = act_y + bob (bob = 0 unless FISH_BOB_EN).
  - Compute dx = pix_x - act_x and dy = pix_y - eff_y.
  - in_spr = act_show & pix_valid & (pix_x >= act_x) & ({1'b0,pix_x} < {1'b0,act_x}+SPR_W) & (pix_y >= eff_y) & ({1'b0,pix_y} < {1'b0,eff_y}+SPR_H).
  - Bounds compare in 11 bits, so there is no wrap at the right or bottom screen edge; a partially off-screen sprite is clipped naturally.
- ROM address (combinational):
  - rom_row = dy[3:0].
  - rom_col = act_flip ? (SPR_W-1 - dx[4:0]) : dx[4:0].
  - Both are forced to 0 when in_spr = 0.
- Stage 1: register in_spr and pix_valid. Colour arrives from the ROM this cycle.
- Stage 2 (outputs, registered):
  - out_valid = s1_valid.
  - out_hit = s1_in & (rom_data != KEY_COLOR).
  - out_color = out_hit ? rom_data : 0.
- Latency: fixed 2 clocks from pix_* to out_*; the pipeline never stalls.
- Reset (async, any time, including mid-line):
  - All pipeline regs, out_valid, out_hit and out_color clear to 0.
  - Active and shadow regs go to x=0, y=0, flip=0, show=0; FSM goes to CLEAN.
  - Nothing is drawn until the first update is applied at a frame_tick.
- Update values are not range-checked. x up to 1023 is accepted; the sprite is simply never hit off-screen.

Optional Feature:
- Macro FISH_BOB_EN.
- Defined:
  - 4-bit frame counter increments on every frame_tick.
  - bob toggles 0<->1 each time the counter wraps (every 16 frames).
  - Counter and bob reset to 0.
  - eff_y = act_y + bob, computed in 11 bits.
- Undefined: no counter; bob is constant 0; eff_y = act_y.

Decomposition:
- Shared package fish_pkg holds:
  - SCREEN_W = 640, SCREEN_H = 480.
  - COORD_W = 10.
  - COLOR_W = 12.
  - KEY_WHITE = 12'hFFF.
  - Sprite dimension constants shared with every sprite ROM.
  - The 2-state update-FSM state typedef.
- One natural sub-module: sprite_pos_shadow (shadow/active registers plus the CLEAN/PENDING FSM), reusable by the hook and boat renderers.

Test Plan:
- Reset then pixel scan with no update -> out_hit = 0 for every pixel; rom_row/rom_col stay at 0.
- upd (x=100, y=50, flip=0, show=1), then frame_tick, then scan pixels (100..131, 50..65):
  - pix (100,50) addresses row 0 col 0.
  - pix (131,65) addresses row 15 col 31.
  - out_* appear exactly 2 clocks later.
  - White ROM words give out_hit = 0; other words give out_hit = 1 with matching out_color.
- Same position with flip=1 -> pix (100,50) drives rom_col = 31; pix (131,50) drives rom_col = 0.
- upd (x=620, y=470) applied -> hits only for pix_x 620..639 and pix_y 470..479; no wrap hits at x = 0..11 or y = 0..5.
- upd_valid mid-frame with no frame_tick -> rendering keeps the old position until the next frame_tick; upd_valid coincident with frame_tick -> the new position applies on the next line.
- FISH_BOB_EN: after 16 frame_ticks, the top row of the sprite moves from y = 50 to y = 51; after 32 ticks it returns to 50. Asserting reset_n low mid-line clears out_valid within the same cycle, asynchronously.
